// File: rtl/ci157_mux.sv
// 74LS157-style 2:1 data selector with active-low strobe, plus a registered
// copy of the selected data and of the select line for clocked consumers.
module ci157_mux #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             select,
    input  logic             strobe_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] S_q,
    output logic             sel_q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;
    logic             sel_d;
    logic             sel_q_r;

    // Selector: the conditional operator lets an X on select propagate to S
    // rather than silently choosing one channel.
    always_comb begin
        data_d = {WIDTH{1'b0}};
        sel_d  = select;
        data_d = strobe_n ? {WIDTH{1'b0}} : (select ? B : A);
    end

    // Output registers load every cycle; reset clears them without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= {WIDTH{1'b0}};
            sel_q_r <= 1'b0;
        end else begin
            data_q  <= data_d;
            sel_q_r <= sel_d;
        end
    end

    assign S     = data_d;
    assign S_q   = data_q;
    assign sel_q = sel_q_r;

endmodule

// File: tb/tb_ci157_mux.sv
// Self-checking bench for ci157_mux: a quad instance and a 1-bit instance,
// each compared against a behavioural model every cycle plus directed checks.
module tb_ci157_mux;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sel4 = 1'b0, stb4 = 1'b0;
    logic [3:0] a4 = 4'h0, b4 = 4'h0;
    logic [3:0] s4, sq4;
    logic       selq4;
    logic       sel1 = 1'b0, stb1 = 1'b0;
    logic [0:0] a1 = 1'b0, b1 = 1'b0;
    logic [0:0] s1, sq1;
    logic       selq1;

    int vectors = 0;
    int errors  = 0;
    bit armed   = 1'b0;

    always #5 clk = ~clk;

    ci157_mux #(.WIDTH(4)) u_quad (
        .clk(clk), .rst(rst), .select(sel4), .strobe_n(stb4),
        .A(a4), .B(b4), .S(s4), .S_q(sq4), .sel_q(selq4)
    );

    ci157_mux #(.WIDTH(1)) u_single (
        .clk(clk), .rst(rst), .select(sel1), .strobe_n(stb1),
        .A(a1), .B(b1), .S(s1), .S_q(sq1), .sel_q(selq1)
    );

    // Reference selector, built bit by bit from the 74157 truth table.
    function automatic logic [63:0] ref_sel(input logic [63:0] a, input logic [63:0] b,
                                            input logic sel, input logic g_n, input int w);
        logic [63:0] r;
        r = 64'd0;
        for (int i = 0; i < w; i++) begin
            if (g_n)      r[i] = 1'b0;
            else if (sel) r[i] = b[i];
            else          r[i] = a[i];
        end
        return r;
    endfunction

    logic [63:0] m_sq4 = 64'd0, m_sq1 = 64'd0;
    logic        m_sel4 = 1'b0, m_sel1 = 1'b0;

    // Model of the registered outputs: last sampled selection, cleared by reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_sq4 <= 64'd0; m_sel4 <= 1'b0;
            m_sq1 <= 64'd0; m_sel1 <= 1'b0;
        end else begin
            m_sq4 <= ref_sel({60'd0, a4}, {60'd0, b4}, sel4, stb4, 4);
            m_sel4 <= sel4;
            m_sq1 <= ref_sel({63'd0, a1}, {63'd0, b1}, sel1, stb1, 1);
            m_sel1 <= sel1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (armed) begin
            check("quad S",     {60'd0, s4},  ref_sel({60'd0, a4}, {60'd0, b4}, sel4, stb4, 4));
            check("quad S_q",   {60'd0, sq4}, m_sq4);
            check("quad sel_q", {63'd0, selq4}, {63'd0, m_sel4});
            check("single S",   {63'd0, s1},  ref_sel({63'd0, a1}, {63'd0, b1}, sel1, stb1, 1));
            check("single S_q", {63'd0, sq1}, m_sq1);
            check("single sel_q", {63'd0, selq1}, {63'd0, m_sel1});
        end
    end

    logic [4:0] seq_a [5];
    logic [4:0] seq_b [5];

    initial begin
        // Power-up reset
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("reset S_q",   {60'd0, sq4}, 64'd0);
        check("reset sel_q", {63'd0, selq4}, 64'd0);
        @(negedge clk); #2;
        rst = 1'b0;
        armed = 1'b1;

        // 1-bit plain mux, select=0 then select=1: A,B stepped 0->A1->B1->A0->B0
        for (int s = 0; s < 2; s++) begin
            logic [4:0] exp_seq;
            exp_seq = (s == 0) ? 5'b00110 : 5'b01100;   // index 0 is the first step
            @(negedge clk); #2;
            sel1 = s[0]; stb1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
            for (int k = 0; k < 5; k++) begin
                if (k == 1) a1 = 1'b1;
                if (k == 2) b1 = 1'b1;
                if (k == 3) a1 = 1'b0;
                if (k == 4) b1 = 1'b0;
                #1;
                check("single step", {63'd0, s1}, {63'd0, exp_seq[k]});
                #19;
            end
        end

        // Quad: select toggling and strobe
        @(negedge clk); #2;
        a4 = 4'hA; b4 = 4'h5; stb4 = 1'b0; sel4 = 1'b0;
        #1; check("quad sel0", {60'd0, s4}, 64'hA);
        #1; sel4 = 1'b1; #1; check("quad sel1", {60'd0, s4}, 64'h5);
        #1; sel4 = 1'b0; #1; check("quad sel0 again", {60'd0, s4}, 64'hA);
        stb4 = 1'b1; #1; check("strobe sel0", {60'd0, s4}, 64'h0);
        sel4 = 1'b1; #1; check("strobe sel1", {60'd0, s4}, 64'h0);

        // Registered path and asynchronous reset between edges
        @(negedge clk); #2;
        a4 = 4'h3; b4 = 4'hC; sel4 = 1'b1; stb4 = 1'b0;
        @(posedge clk); #1;
        check("reg S_q", {60'd0, sq4}, 64'hC);
        check("reg sel_q", {63'd0, selq4}, 64'd1);
        #1; sel4 = 1'b0; #1;
        check("midcycle S", {60'd0, s4}, 64'h3);
        check("midcycle S_q", {60'd0, sq4}, 64'hC);
        rst = 1'b1; #1;
        check("async S_q", {60'd0, sq4}, 64'h0);
        check("async sel_q", {63'd0, selq4}, 64'd0);
        check("async S", {60'd0, s4}, 64'h3);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post reset S_q", {60'd0, sq4}, 64'h3);

        // Strobe on an edge loads zero data but still loads select
        #2; stb4 = 1'b1; sel4 = 1'b1;
        @(posedge clk); #1;
        check("strobe edge S_q", {60'd0, sq4}, 64'h0);
        check("strobe edge sel_q", {63'd0, selq4}, 64'd1);

        // Reset coincident with a rising edge while S = F
        #2; stb4 = 1'b0; sel4 = 1'b0; a4 = 4'hF;
        @(posedge clk);
        rst = 1'b1;
        #1; check("collision S_q", {60'd0, sq4}, 64'h0);
        @(negedge clk); #2;
        rst = 1'b0;

        // Randomized traffic with occasional resets
        for (int n = 0; n < 300; n++) begin
            @(negedge clk); #2;
            a4 = 4'($urandom); b4 = 4'($urandom);
            sel4 = 1'($urandom); stb4 = ($urandom_range(0, 3) == 0);
            a1 = 1'($urandom); b1 = 1'($urandom);
            sel1 = 1'($urandom); stb1 = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 19) == 0);
        end
        @(negedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
